// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-extension stage.
// Format codes, the buffered entry record and the stage occupancy states.
package imm_pkg;

  localparam int DW    = 16;
  localparam int FMT_W = 3;

  // Immediate-format code from the decoder.
  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_SE8  = 3'd1,
    FMT_ZE8  = 3'd2,
    FMT_ZE3  = 3'd3,
    FMT_ZE7  = 3'd4,
    FMT_ZE5  = 3'd5,
    FMT_SE6  = 3'd6,
    FMT_SE11 = 3'd7
  } imm_fmt_e;

  // One buffered instruction with its extended immediate.
  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] imm;
    imm_fmt_e      fmt;
  } imm_entry_t;

  // Stage occupancy, derived from the main/skid valid bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/imm_extend_unit.sv
// Combinational immediate extractor: selects the instruction field named by
// the format code and sign- or zero-extends it to 16 bits.
module imm_extend_unit
  import imm_pkg::*;
(
  input  logic [DW-1:0] instr,
  input  imm_fmt_e      fmt,
  output logic [DW-1:0] imm
);

  // Field select and extension per format code.
  always_comb begin
    // NOTE: a default before the case guarantees every path assigns imm, so no latch is inferred.
    imm = '0;
    case (fmt)
      FMT_NONE: imm = '0;
      FMT_SE8:  imm = {{8{instr[7]}}, instr[7:0]};
      FMT_ZE8:  imm = {8'h00, instr[7:0]};
      FMT_ZE3:  imm = {13'h0000, instr[8:6]};
      FMT_ZE7:  imm = {9'h000, instr[6:0]};
      FMT_ZE5:  imm = {11'h000, instr[10:6]};
      FMT_SE6:  imm = {{10{instr[5]}}, instr[5:0]};
      FMT_SE11: imm = {{5{instr[10]}}, instr[10:0]};
      default:  imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-generation stage between fetch and execute.
// Main register drives out_*, a skid register absorbs one extra entry so
// in_ready is a pure register output. flush empties the stage.
// Optional: define IMM_STALL_CNT_EN to add a saturating stall_cnt output.
module imm_extend_stage
  import imm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_instr,
  input  logic [FMT_W-1:0] in_fmt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_instr,
  output logic [DW-1:0]    out_imm,
  output logic [FMT_W-1:0] out_fmt
`ifdef IMM_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  imm_entry_t   main_q, main_d;
  imm_entry_t   skid_q, skid_d;
  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  stage_state_e state, next_state;
  logic [DW-1:0] ext_imm;
  imm_entry_t   in_entry;
  logic         acc;
  logic         take;

  imm_extend_unit u_ext (
    .instr (in_instr),
    .fmt   (imm_fmt_e'(in_fmt)),
    .imm   (ext_imm)
  );

  // Pack the incoming instruction with its extended immediate.
  always_comb begin
    in_entry.instr = in_instr;
    in_entry.imm   = ext_imm;
    in_entry.fmt   = imm_fmt_e'(in_fmt);
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_instr = main_q.instr;
  assign out_imm   = main_q.imm;
  assign out_fmt   = main_q.fmt;
  assign acc       = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // Derive the occupancy state from the two valid bits.
  always_comb begin
    state = ST_EMPTY;
    if (skid_valid_q)      state = ST_FULL;
    else if (main_valid_q) state = ST_ONE;
  end

  // Next-state and data-register enables; flush overrides everything.
  always_comb begin
    next_state = state;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_d     = in_entry;
            next_state = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && take) begin
            main_d = in_entry;
          end else if (acc) begin
            skid_d     = in_entry;
            next_state = ST_FULL;
          end else if (take) begin
            next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            main_d     = skid_q;
            next_state = ST_ONE;
          end
        end
        default: next_state = ST_EMPTY;
      endcase
    end
    main_valid_d = (next_state != ST_EMPTY);
    skid_valid_d = (next_state == ST_FULL);
  end

  // Stage registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: data registers are reset too, because out_* must read 0 while in reset.
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

`ifdef IMM_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where output is held by downstream; saturate, clear on flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush)
      stall_cnt_d = '0;
    else if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: per-format extension table,
// backpressure, throughput, flush and asynchronous reset sequences.
module tb_imm_extend_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  in_fmt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic [2:0]  out_fmt;
`ifdef IMM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_pass;
  int n_total;

  imm_extend_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_fmt    (in_fmt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt)
`ifdef IMM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  fmt;
    logic [15:0] exp_imm;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_fmt    = '0;
    out_ready = 1'b1;

    vecs[0]  = '{16'h0780, 3'd1, 16'hFF80};
    vecs[1]  = '{16'h0780, 3'd2, 16'h0080};
    vecs[2]  = '{16'h01C0, 3'd3, 16'h0007};
    vecs[3]  = '{16'h007F, 3'd4, 16'h007F};
    vecs[4]  = '{16'h07C0, 3'd5, 16'h001F};
    vecs[5]  = '{16'h0020, 3'd6, 16'hFFE0};
    vecs[6]  = '{16'h0400, 3'd7, 16'hFC00};
    vecs[7]  = '{16'hFFFF, 3'd0, 16'h0000};
    vecs[8]  = '{16'h007F, 3'd1, 16'h007F};
    vecs[9]  = '{16'h03FF, 3'd7, 16'h03FF};
    vecs[10] = '{16'hF83F, 3'd5, 16'h0000};
    vecs[11] = '{16'hFFDF, 3'd6, 16'h001F};

    // Reset state
    #12;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_instr", {16'd0, out_instr}, 32'd0);
    check("reset_out_imm",   {16'd0, out_imm},   32'd0);
    reset = 1'b0;
    step();

    // Extension table, out_ready held high, 1-cycle latency
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_fmt   = vecs[i].fmt;
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      in_instr = 16'hxxxx;
      in_fmt   = 3'bxxx;
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_out_instr", i), {16'd0, out_instr}, {16'd0, vecs[i].instr});
      check($sformatf("vec%0d_out_imm", i),   {16'd0, out_imm},   {16'd0, vecs[i].exp_imm});
      check($sformatf("vec%0d_out_fmt", i),   {29'd0, out_fmt},   {29'd0, vecs[i].fmt});
      step();
      check($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: two accepts with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'h1111;
    in_fmt    = 3'd0;
    step();
    in_instr = 16'h2222;
    check("bp_in_ready_one", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_in_ready_full", {31'd0, in_ready},  32'd0);
    check("bp_hold_instr",    {16'd0, out_instr}, 32'h1111);
    check("bp_hold_valid",    {31'd0, out_valid}, 32'd1);
    step();
    check("bp_stable_instr",  {16'd0, out_instr}, 32'h1111);
    out_ready = 1'b1;
    step();
    check("bp_second_instr", {16'd0, out_instr}, 32'h2222);
    check("bp_second_valid", {31'd0, out_valid}, 32'd1);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Full throughput: 8 back-to-back with no bubbles
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        in_instr = 16'h3000 + 16'(i);
        in_fmt   = 3'd2;
        check($sformatf("tp%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (i > 0) begin
        check($sformatf("tp%0d_valid", i), {31'd0, out_valid}, 32'd1);
        check($sformatf("tp%0d_instr", i), {16'd0, out_instr}, {16'd0, 16'h3000 + 16'(i - 1)});
      end
      step();
    end
    check("tp_drained", {31'd0, out_valid}, 32'd0);

    // Flush in FULL with in_valid high
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'hAAAA;
    step();
    in_instr = 16'hBBBB;
    step();
    check("fl_full", {31'd0, in_ready}, 32'd0);
    flush    = 1'b1;
    in_instr = 16'hDEAD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready",  {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    step();
    check("fl_no_ghost", {31'd0, out_valid}, 32'd0);

    // Flush in ONE with a handshake in the same cycle: input dropped
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'h4444;
    step();
    flush    = 1'b1;
    in_instr = 16'hBEEF;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl1_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("fl1_no_ghost", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;

    // Async reset mid-cycle while in ONE
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'h5A5A;
    in_fmt    = 3'd1;
    step();
    in_valid = 1'b0;
    check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    check("ar_pre_imm",   {16'd0, out_imm},   32'h005A);
    #2;
    reset = 1'b1;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_out_imm",   {16'd0, out_imm},   32'd0);
    check("ar_out_instr", {16'd0, out_instr}, 32'd0);
    check("ar_in_ready",  {31'd0, in_ready},  32'd1);
    #2;
    reset = 1'b0;
    step();
    check("ar_stays_empty", {31'd0, out_valid}, 32'd0);

`ifdef IMM_STALL_CNT_EN
    // Stall counter: 5 stalled cycles, then flush clears it
    check("sc_zero", {16'd0, stall_cnt}, 32'd0);
    in_valid = 1'b1;
    in_instr = 16'h6666;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("sc_five", {16'd0, stall_cnt}, 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sc_flushed", {16'd0, stall_cnt}, 32'd0);
    out_ready = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Registered immediate-generation stage between fetch and execute in the 16-bit ARM datapath.
- Accepts a 16-bit instruction plus a 3-bit immediate-format code from the decoder and produces the instruction with its 16-bit extended immediate.
- Provides valid/ready handshakes on both sides, a 2-entry skid buffer and a pipeline flush.

Parameters:
- DW, 16, instruction and immediate width. Fixed at 16; any other value is unsupported.
- FMT_W, 3, width of the immediate-format code.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  discards all buffered entries (branch redirect).
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  16  raw instruction.
- in_fmt  input  3  immediate format code (see Behaviour).
- out_valid  output  1  out_* signals are valid.
- out_ready  input  1  downstream accepts this cycle.
- out_instr  output  16  registered instruction.
- out_imm  output  16  registered extended immediate.
- out_fmt  output  3  registered format code.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Format codes and immediate source:
  - 0 NONE → imm = 0x0000.
  - 1 SE8 → instr[7:0], sign-extended.
  - 2 ZE8 → instr[7:0], zero-extended.
  - 3 ZE3 → instr[8:6], zero-extended.
  - 4 ZE7 → instr[6:0], zero-extended.
  - 5 ZE5 → instr[10:6], zero-extended.
  - 6 SE6 → instr[5:0], sign-extended.
  - 7 SE11 → instr[10:0], sign-extended.
  - Sign-extend: bits above the field copy the field MSB. Zero-extend: bits above the field are 0.
- Extension is computed combinationally on the input side. The result is captured in the same register as the instruction.
- Latency: 1 cycle from an input handshake (in_valid && in_ready) to out_valid, provided the stage is empty.
- Storage: main register (drives out_*) plus one skid register.
- State machine, derived from the two valid bits:
  - EMPTY: main and skid invalid.
  - ONE: main valid only.
  - FULL: both valid.
- in_ready = !skid_valid. It is a pure register output, with no combinational path from out_ready.
- Transitions (acc = input handshake, take = out_valid && out_ready):
  - EMPTY, acc → ONE.
  - ONE: acc && take → ONE (main reloaded). acc && !take → FULL (input goes to skid). !acc && take → EMPTY.
  - FULL: take → ONE (skid moves to main). No acceptance is possible because in_ready = 0.
- Ordering: strictly FIFO. out_* stay stable while out_valid && !out_ready.
- flush: next state is EMPTY regardless of in_valid or out_ready. An input handshake in the flush cycle is dropped. flush has priority over all transitions.
- Reset, including reset asserted mid-transfer:
  - All state cleared immediately.
  - out_valid = 0; out_instr, out_imm, out_fmt = 0.
  - in_ready = 1 (skid empty).
  - In-flight data is lost.
- Data registers load only on an enable. No X propagation from inputs while in_valid = 0.

Optional Feature:
- Macro IMM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits), reset to 0.
  - Increments each cycle out_valid && !out_ready, saturating at 0xFFFF.
  - Cleared by flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package imm_pkg:
  - Enum imm_fmt_e, 3-bit, with codes 0–7 as above.
  - Localparam DW = 16.
  - Struct imm_entry_t {instr, imm, fmt}.
- Sub-module imm_extend_unit: combinational (instr, fmt) → imm, using the existing 16-bit extenders. The stage instantiates one copy on its input path.

Test Plan:
- Extension per format, out_ready held 1:
  - instr 0x0780, fmt SE8 → imm 0xFF80.
  - instr 0x0780, fmt ZE8 → imm 0x0080.
  - instr 0x01C0, fmt ZE3 → imm 0x0007.
  - instr 0x007F, fmt ZE7 → imm 0x007F.
  - instr 0x07C0, fmt ZE5 → imm 0x001F.
  - instr 0x0020, fmt SE6 → imm 0xFFE0.
  - instr 0x0400, fmt SE11 → imm 0xFC00.
  - fmt NONE → imm 0x0000.
  - Each result appears exactly 1 cycle after the handshake.
- Backpressure: out_ready = 0 while sending 0x1111 then 0x2222.
  - in_ready drops the cycle after the second accept.
  - out_instr holds 0x1111.
  - Raise out_ready → 0x1111, then 0x2222 on consecutive cycles; in_ready returns to 1.
- Full throughput: 8 back-to-back instructions with out_ready = 1 → 8 consecutive out_valid cycles, in order, no bubbles.
- Flush in FULL while in_valid = 1 → next cycle out_valid = 0 and in_ready = 1; the flushed-cycle input never appears.
- Async reset asserted mid-cycle in ONE → out_valid, out_imm, out_instr = 0 before the next clk edge; in_ready = 1.
- With IMM_STALL_CNT_EN: hold out_ready = 0 for 5 cycles with out_valid = 1 → stall_cnt = 5; flush → 0.
